// File: rtl/eth_tx_framer.sv
// eth_tx_framer: GMII transmit framer adding preamble/SFD and inter-frame gap; ETH_TX_FCS_EN adds min-length pad and CRC-32 FCS
module eth_tx_framer #(
  parameter int IFG_BYTES = 12,
  parameter int MIN_FRAME = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [7:0]  tx_data,
  output logic [1:0]  tx_ctl,
  output logic        busy,
  output logic [15:0] frame_count,
  output logic [15:0] underrun_count
);
  typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, PAD, FCS, IFG, DROP} state_t;
  localparam logic [7:0] IFG_LAST = 8'(IFG_BYTES);
  state_t state, state_n;
  logic [7:0] cnt, cnt_n, data_n;
  logic [1:0] ctl_n;
  logic fc_inc, uc_inc;
  assign in_ready = state == DATA || state == DROP;
`ifdef ETH_TX_FCS_EN
  localparam logic [10:0] MIN_LEN = 11'(MIN_FRAME);
  logic [31:0] crc, crc_n;
  logic [10:0] bcnt, bcnt_n, bcnt_inc;
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
    return r;
  endfunction
  assign bcnt_inc = &bcnt ? bcnt : bcnt + 11'd1;
  always_ff @(posedge clk) begin
    if (reset) begin
      crc <= 32'hFFFFFFFF;
      bcnt <= 11'd0;
    end else begin
      crc <= crc_n;
      bcnt <= bcnt_n;
    end
  end
`endif
  always_comb begin
    state_n = state;
    cnt_n = 8'd0;
    data_n = 8'h00;
    ctl_n = 2'b00;
    fc_inc = 1'b0;
    uc_inc = 1'b0;
`ifdef ETH_TX_FCS_EN
    crc_n = crc;
    bcnt_n = bcnt;
`endif
    case (state)
      IDLE: if (in_valid) begin
        state_n = PRE;
        data_n = 8'h55;
        ctl_n = 2'b11;
      end
      PRE: begin
        data_n = 8'h55;
        ctl_n = 2'b11;
        cnt_n = cnt + 8'd1;
        state_n = cnt == 8'd5 ? SFD : PRE;
      end
      SFD: begin
        data_n = 8'hD5;
        ctl_n = 2'b11;
        state_n = DATA;
`ifdef ETH_TX_FCS_EN
        crc_n = 32'hFFFFFFFF;
        bcnt_n = 11'd0;
`endif
      end
      DATA: if (!in_valid) begin
        ctl_n = 2'b01;
        uc_inc = 1'b1;
        state_n = DROP;
      end else begin
        data_n = in_data;
        ctl_n = 2'b11;
`ifdef ETH_TX_FCS_EN
        crc_n = crc_byte(crc, in_data);
        bcnt_n = bcnt_inc;
        if (in_last) state_n = bcnt_inc < MIN_LEN ? PAD : FCS;
`else
        fc_inc = in_last;
        if (in_last) state_n = IFG;
`endif
      end
`ifdef ETH_TX_FCS_EN
      PAD: begin
        ctl_n = 2'b11;
        crc_n = crc_byte(crc, 8'h00);
        bcnt_n = bcnt_inc;
        state_n = bcnt_inc >= MIN_LEN ? FCS : PAD;
      end
      FCS: begin
        data_n = ~crc[7:0];
        ctl_n = 2'b11;
        crc_n = crc >> 8;
        cnt_n = cnt == 8'd3 ? 8'd0 : cnt + 8'd1;
        fc_inc = cnt == 8'd3;
        state_n = cnt == 8'd3 ? IFG : FCS;
      end
`endif
      IFG: begin
        cnt_n = cnt + 8'd1;
        state_n = cnt == IFG_LAST ? IDLE : IFG;
      end
      DROP: if (in_valid && in_last) state_n = IFG;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= 8'd0;
      tx_data <= 8'h00;
      tx_ctl <= 2'b00;
      busy <= 1'b0;
      frame_count <= 16'd0;
      underrun_count <= 16'd0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      tx_data <= data_n;
      tx_ctl <= ctl_n;
      busy <= state_n != IDLE;
      frame_count <= frame_count + {15'd0, fc_inc};
      underrun_count <= underrun_count + {15'd0, uc_inc};
    end
  end
endmodule
